// File: rtl/mano_io_ctrl_pkg.sv
// Shared definitions for the Mano terminal I/O controller: byte width,
// input/output side state codes and the pace-counter width helper.
package mano_io_ctrl_pkg;

    localparam int IOWIDTH = 8;

    typedef enum logic [0:0] {
        IST_IDLE = 1'b0,
        IST_PEND = 1'b1
    } ist_e;

    typedef enum logic [2:0] {
        OST_INIT = 3'd0,
        OST_IDLE = 3'd1,
        OST_CAPT = 3'd2,
        OST_SEND = 3'd3,
        OST_PACE = 3'd4
    } ost_e;

    // A zero pace still needs a one-bit counter.
    function automatic int pace_width(input int cycles);
        if (cycles < 1) return 1;
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/mano_io_fifo.sv
// Small synchronous keyboard FIFO; occupancy counter drives full/empty,
// pointers wrap naturally because DEPTH is a power of two.
module mano_io_fifo
    import mano_io_ctrl_pkg::*;
#(
    parameter int DATA_W = IOWIDTH,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mano_io_ctrl.sv
// Terminal I/O controller beside the Mano datapath: keyboard FIFO feeding
// INPR/FGI, and OUTR capture feeding a paced printer handshake with FGO.
module mano_io_ctrl
    import mano_io_ctrl_pkg::*;
#(
    parameter int IOW        = IOWIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int PACE_CYC   = 16
) (
    input  logic           mclk,
    input  logic           mrst,
    input  logic [IOW-1:0] kbd_data,
    input  logic           kbd_valid,
    output logic           kbd_ready,
    output logic [IOW-1:0] inprin,
    output logic           inpr_ld,
    output logic           fgi_set,
    input  logic           inp_ack,
    input  logic [IOW-1:0] outr,
    input  logic           out_wr,
    output logic [IOW-1:0] prn_data,
    output logic           prn_valid,
    input  logic           prn_ready,
    output logic           fgo_set,
    output logic           ovf_err
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = pace_width(PACE_CYC);

    logic [IOW-1:0] fifo_head;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count_unused;
    logic           pop;

    ist_e ist, ist_n;

    assign kbd_ready = !fifo_full;
    assign fgi_set   = inpr_ld;

    mano_io_fifo #(
        .DATA_W (IOW),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (mclk),
        .rst_n (mrst),
        .push  (kbd_valid),
        .din   (kbd_data),
        .pop   (pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count_unused)
    );

    always_comb begin
        ist_n = ist;
        pop   = 1'b0;
        case (ist)
            IST_IDLE: begin
                if (!fifo_empty) begin
                    pop   = 1'b1;
                    ist_n = IST_PEND;
                end
            end
            IST_PEND: begin
                if (inp_ack) ist_n = IST_IDLE;
            end
            default: ist_n = IST_IDLE;
        endcase
    end

    // The popped byte and its load strobe both appear the cycle after the pop edge.
    always_ff @(posedge mclk or negedge mrst) begin
        if (!mrst) begin
            ist     <= IST_IDLE;
            inprin  <= '0;
            inpr_ld <= 1'b0;
        end else begin
            ist     <= ist_n;
            inpr_ld <= pop;
            if (pop) inprin <= fifo_head;
        end
    end

    ost_e          ost, ost_n;
    logic [PW-1:0] pace_cnt, pace_cnt_n;
    logic          capt;
    logic          fgo_n;

    assign prn_valid = (ost == OST_SEND);

    always_comb begin
        ost_n      = ost;
        pace_cnt_n = pace_cnt;
        capt       = 1'b0;
        case (ost)
            OST_INIT: ost_n = OST_IDLE;
            OST_IDLE: begin
                if (out_wr) ost_n = OST_CAPT;
            end
            OST_CAPT: begin
                capt  = 1'b1;
                ost_n = OST_SEND;
            end
            OST_SEND: begin
                if (prn_ready) begin
                    ost_n      = OST_PACE;
                    pace_cnt_n = PW'(PACE_CYC);
                end
            end
            OST_PACE: begin
                if (pace_cnt == '0) ost_n = OST_IDLE;
                else                pace_cnt_n = pace_cnt - PW'(1);
            end
            default: ost_n = OST_INIT;
        endcase
        // Registered FGO request: high in the cycle the pace counter sits at zero.
        fgo_n = (ost == OST_INIT) || ((ost_n == OST_PACE) && (pace_cnt_n == '0));
    end

    always_ff @(posedge mclk or negedge mrst) begin
        if (!mrst) begin
            ost      <= OST_INIT;
            pace_cnt <= '0;
            prn_data <= '0;
            fgo_set  <= 1'b0;
            ovf_err  <= 1'b0;
        end else begin
            ost      <= ost_n;
            pace_cnt <= pace_cnt_n;
            fgo_set  <= fgo_n;
            if (capt) prn_data <= outr;
            if (out_wr && (ost != OST_IDLE)) ovf_err <= 1'b1;
        end
    end

endmodule
